// File: rtl/multiword_add_seq.sv
`default_nettype none
//============================================================================
// Module   : multiword_add_seq (with helper serial_adder)
// Brief    : Streaming multi-word adder; one word per beat, LS word first,
//            carry chained between beats, registered valid/ready output.
// Revision : 1.0 - initial release
//============================================================================

module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

module multiword_add_seq #(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             in_cin_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_s_o,
    output logic             out_last_o,
    output logic             out_cout_o,
    output logic             out_err_o
);

    localparam int               CNT_W      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_WORDS - 1);

    logic             r_first;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_s;
    logic             r_out_last;
    logic             r_out_cout;
    logic             r_out_err;

    logic             w_accept;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_cnt_end;
    logic             w_pkt_end;

    // Ready depends only on registered state and the consumer, never on in_valid_i.
    assign in_ready_o = !r_out_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_cin      = r_first ? in_cin_i : r_c;
    assign w_cnt_end  = (r_cnt == c_cnt_last);
    assign w_pkt_end  = in_last_i || w_cnt_end;

    serial_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (in_a_i),
        .b    (in_b_i),
        .cin  (w_cin),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_first     <= 1'b1;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_s     <= w_sum;
            r_out_last  <= w_pkt_end;
            r_out_cout  <= w_pkt_end && w_cout;
            // An explicit last on the final permitted word is a clean end, not a truncation.
            r_out_err   <= w_cnt_end && !in_last_i;
            if (w_pkt_end) begin
                r_first <= 1'b1;
                r_c     <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_first <= 1'b0;
                r_c     <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
            end
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_s_o     = r_out_s;
    assign out_last_o  = r_out_last;
    assign out_cout_o  = r_out_cout;
    assign out_err_o   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
//============================================================================
// Module   : tb_multiword_add_seq
// Brief    : Directed scenarios plus a randomized stream scored against a
//            packet-level big-integer model of the multi-word adder.
// Revision : 1.0 - initial release
//============================================================================

module tb_multiword_add_seq;

    localparam int WIDTH     = 32;
    localparam int MAX_WORDS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_cin;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_s;
    logic              out_last;
    logic              out_cout;
    logic              out_err;

    int errors = 0;
    int checks = 0;

    logic [34:0] obs_q [$];
    logic [34:0] exp_q [$];
    logic [31:0] ma [$];
    logic [31:0] mb [$];
    logic        mcin;
    logic        mon_en = 1'b0;
    logic        rnd_done;

    multiword_add_seq #(
        .WIDTH     (WIDTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_cin_i    (in_cin),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_s_o     (out_s),
        .out_last_o  (out_last),
        .out_cout_o  (out_cout),
        .out_err_o   (out_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready)
            obs_q.push_back({out_s, out_last, out_cout, out_err});
    end

    function automatic logic [35:0] outs();
        return {out_valid, out_s, out_last, out_cout, out_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_last  = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_cin   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference: a packet is the whole A, B as big integers; result is A+B+cin.
    function automatic void model_close(input logic trunc);
        logic [32*MAX_WORDS:0] ta;
        logic [32*MAX_WORDS:0] tb;
        logic [32*MAX_WORDS:0] ts;
        int n;
        logic fin;
        n  = ma.size();
        ta = '0;
        tb = '0;
        for (int i = 0; i < n; i++) begin
            ta[32*i +: 32] = ma[i];
            tb[32*i +: 32] = mb[i];
        end
        ts = ta + tb + {{(32*MAX_WORDS){1'b0}}, mcin};
        for (int i = 0; i < n; i++) begin
            fin = (i == n - 1);
            exp_q.push_back({ts[32*i +: 32], fin, fin & ts[32*n], fin & trunc});
        end
        ma.delete();
        mb.delete();
    endfunction

    function automatic void model_push(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic last);
        if (ma.size() == 0) mcin = cin;
        ma.push_back(a);
        mb.push_back(b);
        if (last || ma.size() == MAX_WORDS) model_close(!last);
    endfunction

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic last);
        logic acc;
        int   cyc;
        drive(a, b, cin, last);
        model_push(a, b, cin, last);
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) begin
            $display("FAIL random_accept_timeout: in_ready stayed %b, required 1 within 500 cycles", in_ready);
            errors++;
            $fatal(1, "input handshake stalled");
        end
        if ($urandom_range(0, 3) == 0) begin
            idle();
            step();
        end
    endtask

    task automatic test_reset();
        logic [35:0] e;
        rst = 1'b1;
        idle();
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        e = '0;
        checks++;
        if (outs() !== e) begin
            $display("FAIL reset_outputs: got %h required %h", outs(), e);
            errors++;
        end
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
            errors++;
        end
    endtask

    task automatic test_single_word();
        logic [35:0] e;
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        step();
        idle();
        e = {1'b1, 32'h0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (outs() !== e) begin
            $display("FAIL single_word: got %h required %h", outs(), e);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL single_word_drain: out_valid got %b required 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_two_word();
        logic [31:0] a [2] = '{32'hFFFF_FFFF, 32'h0};
        logic [31:0] b [2] = '{32'h1, 32'h0};
        logic [35:0] e [2] = '{{1'b1, 32'h0, 3'b000}, {1'b1, 32'h1, 3'b100}};
        for (int i = 0; i < 2; i++) begin
            drive(a[i], b[i], (i == 0) ? 1'b0 : 1'($urandom), i == 1);
            step();
            checks++;
            if (outs() !== e[i]) begin
                $display("FAIL two_word[%0d]: got %h required %h", i, outs(), e[i]);
                errors++;
            end
        end
        idle();
    endtask

    task automatic test_four_word();
        logic [35:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(32'hFFFF_FFFF, 32'h0, (i == 0) ? 1'b1 : 1'($urandom), i == 3);
            step();
            e = {1'b1, 32'h0, i == 3, i == 3, 1'b0};
            checks++;
            if (outs() !== e) begin
                $display("FAIL four_word[%0d]: got %h required %h", i, outs(), e);
                errors++;
            end
        end
        drive(32'h1, 32'h1, 1'b0, 1'b1);
        step();
        idle();
        e = {1'b1, 32'h2, 3'b100};
        checks++;
        if (outs() !== e) begin
            $display("FAIL four_word_next: got %h required %h", outs(), e);
            errors++;
        end
    endtask

    task automatic test_truncate();
        logic [35:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(32'hFFFF_FFFF, 32'h0, (i == 0) ? 1'b1 : 1'($urandom), 1'b0);
            step();
            e = {1'b1, 32'h0, i == 3, i == 3, i == 3};
            checks++;
            if (outs() !== e) begin
                $display("FAIL truncate[%0d]: got %h required %h", i, outs(), e);
                errors++;
            end
        end
        drive(32'h5, 32'h6, 1'b0, 1'b0);
        step();
        e = {1'b1, 32'hB, 3'b000};
        checks++;
        if (outs() !== e) begin
            $display("FAIL truncate_newpkt: got %h required %h", outs(), e);
            errors++;
        end
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'($urandom), 1'b1);
        step();
        idle();
        e = {1'b1, 32'hFFFF_FFFE, 3'b110};
        checks++;
        if (outs() !== e) begin
            $display("FAIL truncate_newpkt_end: got %h required %h", outs(), e);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] e;
        out_ready = 1'b1;
        drive(32'd10, 32'd1, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        drive(32'd20, 32'd2, 1'b0, 1'b0);
        e = {1'b1, 32'd11, 3'b000};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || outs() !== e) begin
                $display("FAIL backpressure_hold[%0d]: ready=%b out=%h required ready=0 out=%h", i, in_ready, outs(), e);
                errors++;
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL backpressure_release: in_ready got %b required 1", in_ready);
            errors++;
        end
        step();
        e = {1'b1, 32'd22, 3'b000};
        checks++;
        if (outs() !== e) begin
            $display("FAIL backpressure_word1: got %h required %h", outs(), e);
            errors++;
        end
        drive(32'd30, 32'd3, 1'b0, 1'b1);
        step();
        idle();
        e = {1'b1, 32'd33, 3'b100};
        checks++;
        if (outs() !== e) begin
            $display("FAIL backpressure_word2: got %h required %h", outs(), e);
            errors++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [35:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        e = '0;
        checks++;
        if (outs() !== e || in_ready !== 1'b1) begin
            $display("FAIL reset_mid: out=%h ready=%b required out=%h ready=1", outs(), in_ready, e);
            errors++;
        end
        drive(32'd3, 32'd4, 1'b1, 1'b1);
        step();
        idle();
        e = {1'b1, 32'd8, 3'b100};
        checks++;
        if (outs() !== e) begin
            $display("FAIL reset_mid_next: got %h required %h", outs(), e);
            errors++;
        end
        step();
    endtask

    task automatic test_random();
        int nw;
        int hl;
        logic [31:0] a;
        logic [31:0] b;
        int nmin;
        obs_q.delete();
        exp_q.delete();
        ma.delete();
        mb.delete();
        mon_en   = 1'b1;
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    nw = $urandom_range(1, 6);
                    hl = (p == 999) ? 1 : int'($urandom_range(0, 3) != 0);
                    for (int i = 0; i < nw; i++) begin
                        a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                        b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                        send_beat(a, b, 1'($urandom), (hl != 0) && (i == nw - 1));
                    end
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && obs_q.size() < exp_q.size(); k++) step();
        mon_en = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL random_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
            errors++;
        end
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                $display("FAIL random_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
                errors++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        test_reset();
        test_single_word();
        test_two_word();
        test_four_word();
        test_truncate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multiword_add_seq.md
# multiword_add_seq

Streaming front/back end for `serial_adder`: accepts operand pairs one WIDTH-bit word per beat (least-significant word first), feeds each word to an internal `serial_adder`, chains that word's carry-out into the next word's carry-in through a register, and emits registered sum words with a final carry-out. Sits between the operand source and the result consumer, turning a single-word combinational adder into a pipelined multi-word adder with valid/ready flow control on both sides.

## Interface
Parameters:
- WIDTH, 32, word width; passed to the internal `serial_adder`.
- MAX_WORDS, 4, maximum words per operand packet; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  synchronous active-high reset.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted when in_valid_i && in_ready_o.
- in_a_i  input  WIDTH  operand A word.
- in_b_i  input  WIDTH  operand B word.
- in_cin_i  input  1  packet carry-in; sampled only on the first beat of a packet.
- in_last_i  input  1  marks the final word of a packet.
- out_valid_o  output  1  result beat valid.
- out_ready_i  input  1  consumer ready.
- out_s_o  output  WIDTH  sum word.
- out_last_o  output  1  final word of packet.
- out_cout_o  output  1  packet carry-out; meaningful only when out_last_o=1, else 0.
- out_err_o  output  1  packet truncated at MAX_WORDS (see below); meaningful only with out_last_o.

## Operation
- State: `first` flag (1 = next accepted beat starts a packet), carry register `c_q`, word counter `cnt` (0..MAX_WORDS-1), one-entry output register.
- Adder carry-in = in_cin_i when first=1, else c_q.
- On accept: output register ← {sum, last, cout, err}; c_q ← adder cout; cnt ← cnt+1.
- End of packet on accept when in_last_i=1 OR cnt==MAX_WORDS-1. Then out_last=1, out_cout=adder cout, first←1, cnt←0, c_q←0.
- Forced end (cnt==MAX_WORDS-1 and in_last_i=0): out_err=1; the next beat starts a new packet (carry not chained).
- out_err=0 whenever in_last_i=1 ends the packet, including on word MAX_WORDS.
- Non-last beats: out_last=0, out_cout=0, out_err=0.
- in_ready_o = !out_valid_o || out_ready_i (single register, full throughput, no combinational path from in_valid_i to in_ready_o).
- Output register holds stable while out_valid_o && !out_ready_i.
- Sum arithmetic is modulo 2^WIDTH per word; the packet result equals (A + B + cin) mod 2^(WIDTH·n), with carry out of bit WIDTH·n-1.

## Timing
- Reset: out_valid_o=0, out_s_o=0, out_last_o=0, out_cout_o=0, out_err_o=0, first=1, c_q=0, cnt=0; in_ready_o=1 the cycle after reset.
- Latency: beat accepted in cycle N appears on outputs in cycle N+1.
- Throughput: one word per cycle when out_ready_i is held high.
- Simultaneous pop and push: accepted in the same cycle; output register is replaced, no bubble.
- Reset mid-packet: partial packet discarded, carry/count cleared, any pending output dropped.
- Single-word packet (in_last_i on first beat): carry-in = in_cin_i, carry-out reported on that beat.

## Test plan
- WIDTH=32, MAX_WORDS=4, one-word packet A=0xFFFFFFFF, B=1, cin=0, last=1 -> next cycle out_s=0, out_last=1, out_cout=1, err=0.
- 2-word packet A={0x0,0xFFFFFFFF}, B={0x0,0x1}, cin=0 -> words 0x00000000 (last=0, cout=0), then 0x00000001 (last=1, cout=0): carry chained.
- 4-word packet, all words 0xFFFFFFFF + 0, cin=1, last on word 4 -> four 0x00000000 words, final cout=1, err=0; then a 1-word packet 1+1, cin=0 -> 0x00000002 (carry not leaked).
- 5 beats without in_last_i -> beat 4 out_last=1, err=1; beat 5 treated as new packet with its own in_cin_i.
- Back-pressure: out_ready_i=0 for 3 cycles during a 3-word stream -> in_ready_o=0 while full, out_s held stable, no word lost or duplicated; random ready toggling over 1000 packets matches the reference model.
- Assert rst_i after word 2 of a 4-word packet -> outputs return to reset values next cycle; the following packet sums correctly using in_cin_i.
